pb_card_responder: RTL and testbench
====================================

PB_CARD_RESPONDER -- requirements
Module: pb_card_responder

Interface
REQ-001 Parameter BOARD_INDEX, default 0: card position 0..3; the card is selected when BOARD_X[BOARD_INDEX]=1.
REQ-002 Parameter CONV_CYCLES, default 27: ADC conversion time in clocks (1 us at 27 MHz).
REQ-003 Port: clock  in  1  system clock; the block uses one clock only.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: BOARD_X  in  4  board select from the initiator, one bit per card.
REQ-006 Port: AddessPortPin  in  3  register address.
REQ-007 Port: RdP  in  1  read strobe, active-low.
REQ-008 Port: WrP  in  1  write strobe, active-low; RdP=0 with WrP=0 together means test-address mode.
REQ-009 Port: LampResetPin  in  1  lamp clear, active-low.
REQ-010 Port: bus_data_in  in  8  data driven by the initiator.
REQ-011 Port: bus_data_out  out  8  read data back to the initiator.
REQ-012 Port: bus_data_oe  out  1  1 = responder drives the data bus.
REQ-013 Port: lamp_state  out  32  lamp registers 0..3 concatenated, register 0 in bits [7:0].
REQ-014 Port: wr_event  out  1  one-clock pulse on each accepted write.

Function
REQ-015 RdP, WrP, LampResetPin and BOARD_X shall pass through 2-flop synchronizers; all decisions use the synchronized values.
REQ-016 Register map:
- 0..3: lamp registers, read/write.
- 4: scratch register, read/write.
- 5: status, read-only, value {7'b0, adc_busy}.
- 6: ADC control, write-only; data bits [1:0] select the channel; reads return 0.
- 7: ADC result, read-only, value {channel[1:0], sample_count[5:0]}.
REQ-017 Bus FSM states are IDLE, READ, WRITE and TEST.
- IDLE->READ: selected, RdP=0, WrP=1.
- IDLE->WRITE: selected, WrP=0, RdP=1.
- IDLE->TEST: selected, RdP=0 and WrP=0.
- Any state->IDLE: the card is deselected or both strobes are high.
REQ-018 READ shall assert bus_data_oe and present the addressed register on bus_data_out, registered, with both valid no later than 4 clocks after RdP falls at the pin.
REQ-019 TEST shall assert bus_data_oe and drive {4'hA, 2'b00, BOARD_INDEX[1:0]}.
REQ-020 WRITE shall update nothing until WrP rises; on that synchronized rising edge it shall latch bus_data_in into the register at the current address and pulse wr_event for one clock.
REQ-021 Writes to addresses 5 and 7 shall be ignored, with no register change and no wr_event pulse.
REQ-022 bus_data_oe shall be 0 in IDLE and WRITE, and shall fall within 3 clocks of RdP rising or the card being deselected.
REQ-023 ADC FSM states are ADC_IDLE, ADC_BUSY and ADC_DONE.
- A write to register 6 in ADC_IDLE or ADC_DONE shall latch the channel and enter ADC_BUSY.
- ADC_BUSY shall last exactly CONV_CYCLES clocks, then enter ADC_DONE with sample_count incremented by 1.
REQ-024 sample_count shall be 6 bits wide and wrap from 63 to 0.
REQ-025 A write to register 6 during ADC_BUSY shall be ignored and shall not extend the conversion; wr_event shall still pulse.
REQ-026 adc_busy shall be 1 only in ADC_BUSY.
REQ-027 While synchronized LampResetPin=0, lamp registers 0..3 shall read as 0x00; a write to 0..3 in the same clock shall lose to the clear.
REQ-028 A strobe that begins while the card is deselected shall be ignored until both strobes are high again.

Reset
REQ-029 Asynchronous reset, active-low, shall force the following, regardless of any operation in progress:
- bus_data_out=0x00, bus_data_oe=0, wr_event=0, lamp_state=0.
- All registers 0, sample_count=0.
- Both FSMs idle and synchronizers cleared.
REQ-030 After reset releases, the first strobe shall be recognized no earlier than 2 clocks later.

Structure
REQ-031 The state enums, the register address constants (ADDR_LAMP0..ADDR_ADC_RESULT) and the test-ID nibble 4'hA shall live in a shared package, pb_bus_pkg, also used by the initiator state machines.
REQ-032 The synchronizers plus edge detection shall form one sub-module, pb_strobe_sync, instantiated once for the four control signals.

Verification
REQ-033 Select card 1 (BOARD_X=4'b0010), addr 2, data 0x5C, WrP low for 20 clocks then high -> lamp_state[23:16]=0x5C and a single wr_event pulse.
REQ-034 Read addr 2 on the same card -> bus_data_oe=1 and bus_data_out=0x5C within 4 clocks of RdP falling; bus_data_oe=0 within 3 clocks of RdP rising.
REQ-035 RdP=0 and WrP=0 with card 3 selected (BOARD_INDEX=3) -> bus_data_out=0xA3; the same stimulus on card 0 -> bus_data_out=0xA0.
REQ-036 Sequence:
- Write 0x02 to addr 6, then poll addr 5 -> reads 0x01 for 27 clocks, then 0x00.
- Read addr 7 -> 0x81.
- A second write to addr 6 mid-conversion -> no extension of the busy time.
REQ-037 LampResetPin low while writing 0xFF to addr 0 -> lamp_state=0; a write of 0xFF to addr 4 issued while LampResetPin is low is unaffected and reads back as 0xFF.
REQ-038 Assert reset mid-read -> bus_data_oe=0 immediately; after release, read addr 4 -> 0x00; a write with BOARD_X=4'b0001 on card 1 -> no change.

Source files
------------

// File: rtl/pb_bus_pkg.sv
// rtl/pb_bus_pkg.sv - shared bus/ADC state enums, register map and test ID
// Purpose: definitions shared by the card responder and the initiator state
//          machines so both sides agree on state names and register addresses.
// Ports:   none (package).
package pb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    TEST  = 2'd3
  } bus_state_e;

  typedef enum logic [1:0] {
    ADC_IDLE = 2'd0,
    ADC_BUSY = 2'd1,
    ADC_DONE = 2'd2
  } adc_state_e;

  localparam logic [2:0] ADDR_LAMP0      = 3'd0;
  localparam logic [2:0] ADDR_LAMP1      = 3'd1;
  localparam logic [2:0] ADDR_LAMP2      = 3'd2;
  localparam logic [2:0] ADDR_LAMP3      = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH    = 3'd4;
  localparam logic [2:0] ADDR_STATUS     = 3'd5;
  localparam logic [2:0] ADDR_ADC_CTRL   = 3'd6;
  localparam logic [2:0] ADDR_ADC_RESULT = 3'd7;

  // Upper nibble returned in test-address mode; low bits carry the card slot.
  localparam logic [3:0] TEST_ID = 4'hA;

  // Status and ADC result are read-only: writes there are dropped silently.
  function automatic logic addr_writable(input logic [2:0] addr);
    return !((addr == ADDR_STATUS) || (addr == ADDR_ADC_RESULT));
  endfunction

endpackage

// File: rtl/pb_strobe_sync.sv
// rtl/pb_strobe_sync.sv - 2-flop synchronizers for bus controls plus write-strobe rising edge
// Purpose: bring the asynchronous initiator controls into the clock domain.
// Ports:   clk_i, rst_ni       clock and asynchronous active-low reset
//          rd_n_i, wr_n_i      raw read/write strobes (active-low)
//          lamp_clr_n_i        raw lamp clear (active-low)
//          board_i[3:0]        raw board select
//          *_o                 synchronized copies of the above
//          wr_rise_o           one-clock pulse when synchronized WrP goes 0->1
module pb_strobe_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rd_n_i,
  input  logic       wr_n_i,
  input  logic       lamp_clr_n_i,
  input  logic [3:0] board_i,
  output logic       rd_n_o,
  output logic       wr_n_o,
  output logic       lamp_clr_n_o,
  output logic [3:0] board_o,
  output logic       wr_rise_o
);

  logic [6:0] meta_q;
  logic [6:0] sync_q;
  logic       wr_prev_q;

  // Everything clears to 0 on reset, so the strobes look asserted and the
  // card deselected until the real pin levels have propagated through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q    <= '0;
      sync_q    <= '0;
      wr_prev_q <= 1'b0;
    end else begin
      meta_q    <= {board_i, lamp_clr_n_i, wr_n_i, rd_n_i};
      sync_q    <= meta_q;
      wr_prev_q <= sync_q[1];
    end
  end

  assign rd_n_o       = sync_q[0];
  assign wr_n_o       = sync_q[1];
  assign lamp_clr_n_o = sync_q[2];
  assign board_o      = sync_q[6:3];
  assign wr_rise_o    = sync_q[1] & ~wr_prev_q;

endmodule

// File: rtl/pb_card_responder.sv
// rtl/pb_card_responder.sv - parallel-bus card responder with lamp, scratch and ADC registers
// Purpose: answers initiator reads/writes on an 8-bit strobed bus for one card slot.
// Ports:   clock, reset        clock and asynchronous active-low reset
//          BOARD_X[3:0]        board select, one bit per card
//          AddessPortPin[2:0]  register address
//          RdP, WrP            active-low strobes (both low = test-address mode)
//          LampResetPin        active-low lamp clear
//          bus_data_in[7:0]    write data from the initiator
//          bus_data_out[7:0]   registered read data
//          bus_data_oe         1 while this card drives the bus
//          lamp_state[31:0]    lamp registers 3..0, register 0 in [7:0]
//          wr_event            one-clock pulse per accepted write
module pb_card_responder
  import pb_bus_pkg::*;
#(
  parameter int BOARD_INDEX = 0,
  parameter int CONV_CYCLES = 27
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  BOARD_X,
  input  logic [2:0]  AddessPortPin,
  input  logic        RdP,
  input  logic        WrP,
  input  logic        LampResetPin,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  output logic [31:0] lamp_state,
  output logic        wr_event
);

  localparam logic [1:0] CARD_ID   = BOARD_INDEX[1:0];
  localparam logic [3:0] CARD_MASK = 4'b0001 << CARD_ID;
  localparam logic [7:0] TEST_WORD = {TEST_ID, 2'b00, CARD_ID};
  localparam int         CW        = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

  logic       rd_s, wr_s, lamp_clr_s, wr_rise;
  logic [3:0] board_s;

  pb_strobe_sync u_sync (
    .clk_i        (clock),
    .rst_ni       (reset),
    .rd_n_i       (RdP),
    .wr_n_i       (WrP),
    .lamp_clr_n_i (LampResetPin),
    .board_i      (BOARD_X),
    .rd_n_o       (rd_s),
    .wr_n_o       (wr_s),
    .lamp_clr_n_o (lamp_clr_s),
    .board_o      (board_s),
    .wr_rise_o    (wr_rise)
  );

  bus_state_e     state_q;
  adc_state_e     adc_state_q;
  logic           oe_q, wr_event_q, armed_q;
  logic [7:0]     dout_q;
  logic [3:0][7:0] lamp_q;
  logic [7:0]     scratch_q;
  logic [1:0]     adc_ch_q;
  logic [5:0]     sample_cnt_q;
  logic [CW-1:0]  conv_cnt_q;

  logic       sel, both_high, strobe_any, wr_commit, adc_start, adc_busy;
  logic [7:0] rd_data;

  assign sel        = |(board_s & CARD_MASK);
  assign both_high  = rd_s & wr_s;
  assign strobe_any = ~both_high;
  assign wr_commit  = (state_q == WRITE) && sel && wr_rise && addr_writable(AddessPortPin);
  assign adc_start  = wr_commit && (AddessPortPin == ADDR_ADC_CTRL);
  assign adc_busy   = (adc_state_q == ADC_BUSY);

  always_comb begin
    rd_data = 8'h00;
    case (AddessPortPin)
      ADDR_LAMP0, ADDR_LAMP1, ADDR_LAMP2, ADDR_LAMP3:
        rd_data = lamp_clr_s ? lamp_q[AddessPortPin[1:0]] : 8'h00;
      ADDR_SCRATCH:    rd_data = scratch_q;
      ADDR_STATUS:     rd_data = {7'b0, adc_busy};
      ADDR_ADC_CTRL:   rd_data = 8'h00;
      ADDR_ADC_RESULT: rd_data = {adc_ch_q, sample_cnt_q};
      default:         rd_data = 8'h00;
    endcase
  end

  // armed_q blocks a strobe that started while the card was deselected (or
  // that is left over from the previous transfer): a new transfer needs both
  // strobes seen high first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      oe_q       <= 1'b0;
      dout_q     <= 8'h00;
      wr_event_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      wr_event_q <= wr_commit;
      if (both_high) armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          oe_q   <= 1'b0;
          dout_q <= 8'h00;
          if (!sel) begin
            if (strobe_any) armed_q <= 1'b0;
          end else if (armed_q && strobe_any) begin
            armed_q <= 1'b0;
            if (!rd_s && !wr_s) begin
              state_q <= TEST;
              oe_q    <= 1'b1;
              dout_q  <= TEST_WORD;
            end else if (!rd_s) begin
              state_q <= READ;
              oe_q    <= 1'b1;
              dout_q  <= rd_data;
            end else begin
              state_q <= WRITE;
            end
          end
        end
        READ, TEST: begin
          if (!sel || both_high) begin
            state_q <= IDLE;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
          end else begin
            dout_q  <= (state_q == TEST) ? TEST_WORD : rd_data;
          end
        end
        WRITE: begin
          // The commit itself happens through wr_commit on the WrP rising edge.
          if (!sel || wr_rise) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Lamp clear wins over a same-clock lamp write; scratch is unaffected.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lamp_q    <= '0;
      scratch_q <= 8'h00;
    end else begin
      if (!lamp_clr_s) begin
        lamp_q <= '0;
      end else if (wr_commit && !AddessPortPin[2]) begin
        lamp_q[AddessPortPin[1:0]] <= bus_data_in;
      end
      if (wr_commit && (AddessPortPin == ADDR_SCRATCH)) scratch_q <= bus_data_in;
    end
  end

  // A start request during a conversion is dropped so busy time never stretches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      adc_state_q  <= ADC_IDLE;
      adc_ch_q     <= 2'b00;
      sample_cnt_q <= 6'd0;
      conv_cnt_q   <= '0;
    end else begin
      case (adc_state_q)
        ADC_IDLE, ADC_DONE: begin
          if (adc_start) begin
            adc_ch_q    <= bus_data_in[1:0];
            conv_cnt_q  <= '0;
            adc_state_q <= ADC_BUSY;
          end
        end
        ADC_BUSY: begin
          if (conv_cnt_q == CONV_LAST) begin
            adc_state_q  <= ADC_DONE;
            sample_cnt_q <= sample_cnt_q + 6'd1;
          end else begin
            conv_cnt_q <= conv_cnt_q + CW'(1);
          end
        end
        default: adc_state_q <= ADC_IDLE;
      endcase
    end
  end

  assign bus_data_out = dout_q;
  assign bus_data_oe  = oe_q;
  assign lamp_state   = lamp_q;
  assign wr_event     = wr_event_q;

endmodule

// File: tb/tb_pb_card_responder.sv
// tb/tb_pb_card_responder.sv - self-checking bench for the parallel-bus card responder
module tb_pb_card_responder;

  localparam int CONV = 27;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  board_x = 4'b0000;
  logic [2:0]  addr = 3'd0;
  logic        rdp = 1'b1;
  logic        wrp = 1'b1;
  logic        lamp_rst = 1'b1;
  logic [7:0]  din = 8'h00;

  logic [7:0]  c1_dout, c3_dout, c0_dout;
  logic        c1_oe, c3_oe, c0_oe;
  logic [31:0] c1_lamp, c3_lamp, c0_lamp;
  logic        c1_wev, c3_wev, c0_wev;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  // Reference state of card 1
  logic [7:0] m_lamp [4];
  logic [7:0] m_scratch;
  logic [1:0] m_ch;
  logic [5:0] m_cnt;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  pb_card_responder #(.BOARD_INDEX(1), .CONV_CYCLES(CONV)) u_card1 (
    .clock(clock), .reset(reset), .BOARD_X(board_x), .AddessPortPin(addr),
    .RdP(rdp), .WrP(wrp), .LampResetPin(lamp_rst), .bus_data_in(din),
    .bus_data_out(c1_dout), .bus_data_oe(c1_oe), .lamp_state(c1_lamp), .wr_event(c1_wev));

  pb_card_responder #(.BOARD_INDEX(3), .CONV_CYCLES(CONV)) u_card3 (
    .clock(clock), .reset(reset), .BOARD_X(board_x), .AddessPortPin(addr),
    .RdP(rdp), .WrP(wrp), .LampResetPin(lamp_rst), .bus_data_in(din),
    .bus_data_out(c3_dout), .bus_data_oe(c3_oe), .lamp_state(c3_lamp), .wr_event(c3_wev));

  pb_card_responder #(.BOARD_INDEX(0), .CONV_CYCLES(CONV)) u_card0 (
    .clock(clock), .reset(reset), .BOARD_X(board_x), .AddessPortPin(addr),
    .RdP(rdp), .WrP(wrp), .LampResetPin(lamp_rst), .bus_data_in(din),
    .bus_data_out(c0_dout), .bus_data_oe(c0_oe), .lamp_state(c0_lamp), .wr_event(c0_wev));

  function automatic logic [31:0] m_lamps();
    return {m_lamp[3], m_lamp[2], m_lamp[1], m_lamp[0]};
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    if (a < 3'd4) return m_lamp[a[1:0]];
    if (a == 3'd4) return m_scratch;
    if (a == 3'd7) return {m_ch, m_cnt};
    return 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_lamp[i] = 8'h00;
    m_scratch = 8'h00;
    m_ch = 2'b00;
    m_cnt = 6'd0;
  endtask

  // Full read cycle; t_on/t_off are clocks from the strobe edge to oe change (99 = never).
  task automatic bus_read(input logic [3:0] x, input logic [2:0] a,
                          output logic [7:0] d, output int t_on, output int t_off);
    @(negedge clock); board_x = x; addr = a;
    @(negedge clock); rdp = 1'b0;
    t_on = 99; d = 8'hxx;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (c1_oe === 1'b1) begin t_on = i; d = c1_dout; break; end
    end
    rdp = 1'b1;
    t_off = 99;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (c1_oe === 1'b0) begin t_off = i; break; end
    end
    @(negedge clock);
  endtask

  task automatic bus_write(input logic [3:0] x, input logic [2:0] a, input logic [7:0] d,
                           input int low, output int nev, output int ev_cyc,
                           output logic [31:0] pre_lamp);
    @(negedge clock); board_x = x; addr = a; din = d;
    @(negedge clock); wrp = 1'b0;
    repeat (low) @(negedge clock);
    pre_lamp = c1_lamp;
    wrp = 1'b1;
    nev = 0; ev_cyc = -1;
    repeat (6) begin
      @(negedge clock);
      if (c1_wev === 1'b1) begin nev++; ev_cyc = cyc; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++; if (c1_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b expected 0", c1_oe); end
    tests_run++; if (c1_dout !== 8'h00) begin tests_failed++; $display("FAIL reset_dout: got %h expected 00", c1_dout); end
    tests_run++; if (c1_lamp !== 32'h0) begin tests_failed++; $display("FAIL reset_lamp: got %h expected 0", c1_lamp); end
    tests_run++; if (c1_wev !== 1'b0) begin tests_failed++; $display("FAIL reset_wev: got %b expected 0", c1_wev); end
    tests_run++; if ({c3_oe, c0_oe, c3_wev, c0_wev} !== 4'b0) begin tests_failed++; $display("FAIL reset_others_ctl: got %b expected 0000", {c3_oe, c0_oe, c3_wev, c0_wev}); end
    tests_run++; if ((c3_lamp | c0_lamp) !== 32'h0 || (c3_dout | c0_dout) !== 8'h00) begin tests_failed++; $display("FAIL reset_others_data: got %h/%h expected 0", c3_lamp | c0_lamp, c3_dout | c0_dout); end
    @(negedge clock); reset = 1'b1;
    model_clear();
    repeat (3) @(negedge clock);
  endtask

  task automatic test_write_read();
    int nev, ev, ton, toff; logic [31:0] pre; logic [7:0] d;
    bus_write(4'b0010, 3'd2, 8'h5C, 20, nev, ev, pre);
    tests_run++; if (pre !== 32'h0) begin tests_failed++; $display("FAIL wr_before_rise: got %h expected 0", pre); end
    m_lamp[2] = 8'h5C;
    tests_run++; if (c1_lamp[23:16] !== 8'h5C) begin tests_failed++; $display("FAIL wr_lamp2: got %h expected 5c", c1_lamp[23:16]); end
    tests_run++; if (c1_lamp !== m_lamps()) begin tests_failed++; $display("FAIL wr_lamps: got %h expected %h", c1_lamp, m_lamps()); end
    tests_run++; if (nev != 1) begin tests_failed++; $display("FAIL wr_event_count: got %0d expected 1", nev); end
    bus_read(4'b0010, 3'd2, d, ton, toff);
    tests_run++; if (d !== 8'h5C) begin tests_failed++; $display("FAIL rd_data: got %h expected 5c", d); end
    tests_run++; if (ton > 4) begin tests_failed++; $display("FAIL rd_oe_on: got %0d clocks expected <=4", ton); end
    tests_run++; if (toff > 3) begin tests_failed++; $display("FAIL rd_oe_off: got %0d clocks expected <=3", toff); end
  endtask

  task automatic test_test_mode();
    @(negedge clock); board_x = 4'b1000;
    @(negedge clock); rdp = 1'b0; wrp = 1'b0;
    repeat (4) @(negedge clock);
    tests_run++; if (c3_oe !== 1'b1 || c3_dout !== 8'hA3) begin tests_failed++; $display("FAIL test_card3: got oe=%b data=%h expected 1/a3", c3_oe, c3_dout); end
    tests_run++; if (c1_oe !== 1'b0) begin tests_failed++; $display("FAIL test_card1_quiet: got %b expected 0", c1_oe); end
    rdp = 1'b1; wrp = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++; if (c3_oe !== 1'b0) begin tests_failed++; $display("FAIL test_card3_release: got %b expected 0", c3_oe); end
    @(negedge clock); board_x = 4'b0001;
    @(negedge clock); rdp = 1'b0; wrp = 1'b0;
    repeat (4) @(negedge clock);
    tests_run++; if (c0_oe !== 1'b1 || c0_dout !== 8'hA0) begin tests_failed++; $display("FAIL test_card0: got oe=%b data=%h expected 1/a0", c0_oe, c0_dout); end
    tests_run++; if (c3_oe !== 1'b0) begin tests_failed++; $display("FAIL test_card3_quiet: got %b expected 0", c3_oe); end
    rdp = 1'b1; wrp = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_deselected_strobe();
    logic seen; logic [7:0] d; int ton, toff;
    @(negedge clock); board_x = 4'b0000; addr = 3'd2;
    @(negedge clock); rdp = 1'b0;
    repeat (3) @(negedge clock);
    board_x = 4'b0010;
    seen = 1'b0;
    repeat (8) begin @(negedge clock); if (c1_oe !== 1'b0) seen = 1'b1; end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL late_select_ignored: got oe seen=%b expected 0", seen); end
    rdp = 1'b1;
    repeat (4) @(negedge clock);
    bus_read(4'b0010, 3'd2, d, ton, toff);
    tests_run++; if (d !== m_read(3'd2) || ton > 4) begin tests_failed++; $display("FAIL rearm_read: got %h in %0d expected %h", d, ton, m_read(3'd2)); end
  endtask

  task automatic test_adc();
    int nev, e, nev2, e2, ton, toff; logic [31:0] pre; logic [7:0] d, first, expv;
    logic seen_last, seen_zero;
    for (int ph = 0; ph < 2; ph++) begin
      first = (ph == 0) ? 8'h02 : 8'h03;
      bus_write(4'b0010, 3'd6, first, 4, nev, e, pre);
      tests_run++; if (nev != 1) begin tests_failed++; $display("FAIL adc_start_event: got %0d expected 1", nev); end
      m_ch = first[1:0];
      if (ph == 1) begin
        repeat (3) @(negedge clock);
        bus_write(4'b0010, 3'd6, 8'h00, 3, nev2, e2, pre);
        tests_run++; if (nev2 != 1 || e2 <= e || e2 >= e + CONV) begin tests_failed++; $display("FAIL adc_busy_write_event: got %0d at %0d expected 1 inside (%0d,%0d)", nev2, e2, e, e + CONV); end
      end
      // Status shows busy on the bus for the CONV clocks after the start write.
      @(negedge clock); addr = 3'd5;
      @(negedge clock); rdp = 1'b0;
      seen_last = 1'b0; seen_zero = 1'b0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clock);
        if (cyc > e + CONV + 3) break;
        if (c1_oe === 1'b1) begin
          expv = (cyc > e && cyc <= e + CONV) ? 8'h01 : 8'h00;
          tests_run++;
          if (c1_dout !== expv) begin tests_failed++; $display("FAIL adc_status@%0d: got %h expected %h", cyc - e, c1_dout, expv); end
          if (cyc == e + CONV) seen_last = 1'b1;
          if (cyc == e + CONV + 1) seen_zero = 1'b1;
        end
      end
      rdp = 1'b1;
      repeat (4) @(negedge clock);
      tests_run++; if (!(seen_last && seen_zero)) begin tests_failed++; $display("FAIL adc_edge_observed: got %b%b expected 11", seen_last, seen_zero); end
      m_cnt = m_cnt + 6'd1;
      bus_read(4'b0010, 3'd7, d, ton, toff);
      tests_run++; if (d !== {m_ch, m_cnt}) begin tests_failed++; $display("FAIL adc_result: got %h expected %h", d, {m_ch, m_cnt}); end
    end
  endtask

  task automatic test_lamp_clear();
    int nev, ev, ton, toff; logic [31:0] pre; logic [7:0] d;
    @(negedge clock); lamp_rst = 1'b0;
    repeat (3) @(negedge clock);
    bus_write(4'b0010, 3'd0, 8'hFF, 3, nev, ev, pre);
    for (int i = 0; i < 4; i++) m_lamp[i] = 8'h00;
    tests_run++; if (c1_lamp !== 32'h0) begin tests_failed++; $display("FAIL lamp_clear_wins: got %h expected 0", c1_lamp); end
    bus_write(4'b0010, 3'd4, 8'hFF, 3, nev, ev, pre);
    m_scratch = 8'hFF;
    tests_run++; if (nev != 1) begin tests_failed++; $display("FAIL scratch_event: got %0d expected 1", nev); end
    @(negedge clock); lamp_rst = 1'b1;
    repeat (3) @(negedge clock);
    bus_read(4'b0010, 3'd4, d, ton, toff);
    tests_run++; if (d !== 8'hFF) begin tests_failed++; $display("FAIL scratch_kept: got %h expected ff", d); end
  endtask

  task automatic test_random();
    int nev, ev, ton, toff, low, exp_nev;
    logic [31:0] pre; logic [7:0] d, wd; logic [2:0] a; logic [3:0] x; logic is_wr, selected;
    for (int n = 0; n < 40; n++) begin
      a = 3'($urandom_range(0, 7));
      is_wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      x = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0010;
      selected = x[1];
      if (is_wr && a != 3'd6) begin
        low = $urandom_range(1, 6);
        bus_write(x, a, wd, low, nev, ev, pre);
        exp_nev = (selected && a != 3'd5 && a != 3'd7) ? 1 : 0;
        if (exp_nev == 1 && a < 3'd4) m_lamp[a[1:0]] = wd;
        if (exp_nev == 1 && a == 3'd4) m_scratch = wd;
        tests_run++; if (nev != exp_nev) begin tests_failed++; $display("FAIL rnd_wr_event[%0d] a=%0d x=%b: got %0d expected %0d", n, a, x, nev, exp_nev); end
        tests_run++; if (c1_lamp !== m_lamps()) begin tests_failed++; $display("FAIL rnd_wr_lamps[%0d]: got %h expected %h", n, c1_lamp, m_lamps()); end
      end else begin
        bus_read(x, a, d, ton, toff);
        if (selected) begin
          tests_run++; if (d !== m_read(a) || ton > 4 || toff > 3) begin tests_failed++; $display("FAIL rnd_rd[%0d] a=%0d: got %h on=%0d off=%0d expected %h <=4 <=3", n, a, d, ton, toff, m_read(a)); end
        end else begin
          tests_run++; if (ton != 99) begin tests_failed++; $display("FAIL rnd_rd_desel[%0d] x=%b: got oe after %0d expected none", n, x, ton); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int nev, ev, ton, toff; logic [31:0] pre; logic [7:0] d; logic seen;
    @(negedge clock); board_x = 4'b0010; addr = 3'd2;
    @(negedge clock); rdp = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clock); if (c1_oe === 1'b1) begin seen = 1'b1; break; end end
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL mid_read_started: got %b expected 1", seen); end
    #2 reset = 1'b0;
    #1;
    tests_run++; if (c1_oe !== 1'b0 || c1_dout !== 8'h00 || c1_lamp !== 32'h0) begin tests_failed++; $display("FAIL async_reset: got oe=%b data=%h lamp=%h expected 0", c1_oe, c1_dout, c1_lamp); end
    @(negedge clock); rdp = 1'b1;
    @(negedge clock); reset = 1'b1;
    model_clear();
    repeat (3) @(negedge clock);
    bus_read(4'b0010, 3'd4, d, ton, toff);
    tests_run++; if (d !== 8'h00 || ton > 4) begin tests_failed++; $display("FAIL post_reset_scratch: got %h in %0d expected 00", d, ton); end
    bus_write(4'b0001, 3'd2, 8'h77, 3, nev, ev, pre);
    tests_run++; if (nev != 0 || c1_lamp !== m_lamps()) begin tests_failed++; $display("FAIL other_card_write: got ev=%0d lamp=%h expected 0/%h", nev, c1_lamp, m_lamps()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_test_mode();
    test_deselected_strobe();
    test_adc();
    test_lamp_clear();
    test_random();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
